fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/issue sequencer: walks a program held in an external
// instruction memory, resolves HALT/JUMP/CJUMP locally and hands every other word to execute.
module fetch_sequencer #(
    parameter int MEM_DEPTH   = 128,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             programSelect,
    output logic [7:0]             activeProgram,
    output logic [7:0]             address,
    input  logic [15:0]            instruction,
    output logic [3:0]             condRegAddr,
    input  logic [7:0]             condValue,
    output logic [15:0]            instrOut,
    output logic                   instrValid,
    input  logic                   execReady,
    output logic                   running,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] retiredCount
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HALTED, S_FAULT
    } state_t;

    localparam logic signed [9:0] DEPTH_S = 10'(MEM_DEPTH);

    state_t                 state_q, state_d;
    logic [7:0]             pc_q, pc_d;
    logic [7:0]             prog_q, prog_d;
    logic [15:0]            instr_q, instr_d;
    logic [COUNT_WIDTH-1:0] ret_q, ret_d;
    logic signed [9:0]      target;
    logic                   redirect;

    // Widened signed arithmetic so negative and past-the-end targets stay distinguishable.
    function automatic logic signed [9:0] calc_target(input logic [7:0] pc,
                                                      input logic signed [9:0] off);
        return $signed({2'b00, pc}) + 10'sd1 + off;
    endfunction

    function automatic logic in_range(input logic signed [9:0] t);
        return (t >= 10'sd0) && (t < DEPTH_S);
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            prog_q  <= '0;
            instr_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            prog_q  <= prog_d;
            instr_q <= instr_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        prog_d   = prog_q;
        instr_d  = instr_q;
        ret_d    = ret_q;
        target   = calc_target(pc_q, 10'sd0);
        redirect = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED, S_FAULT: begin
                if (start) begin
                    prog_d  = programSelect;
                    pc_d    = '0;
                    ret_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (instr_q[15:12] == 4'hE) begin
                    state_d = S_HALTED;
                end else if (instr_q[15:12] == 4'h2 && instr_q[11:8] == 4'h0) begin
                    redirect = 1'b1;
                    target   = calc_target(pc_q, $signed({{2{instr_q[7]}}, instr_q[7:0]}));
                end else if (instr_q[15:12] == 4'hC) begin
                    redirect = 1'b1;
                    if (condValue != 8'h00)
                        target = calc_target(pc_q, $signed({{6{instr_q[3]}}, instr_q[3:0]}));
                end else begin
                    state_d = S_ISSUE;
                end
                if (redirect) begin
                    if (in_range(target)) begin
                        pc_d    = target[7:0];
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_ISSUE: begin
                if (execReady) begin
                    ret_d = sat_inc(ret_q);
                    if (in_range(target)) begin
                        pc_d    = target[7:0];
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign address       = pc_q;
    assign activeProgram = prog_q;
    assign condRegAddr   = instr_q[7:4];
    assign instrOut      = instr_q;
    assign instrValid    = (state_q == S_ISSUE);
    assign running       = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE);
    assign halted        = (state_q == S_HALTED);
    assign fault         = (state_q == S_FAULT);
    assign retiredCount  = ret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of single-word decode vectors plus
// hand-written multi-cycle sequences against a behavioural instruction memory and register file.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, execReady;
    logic [7:0]  programSelect, activeProgram, address, condValue;
    logic [15:0] instruction, instrOut;
    logic [3:0]  condRegAddr;
    logic        instrValid, running, halted, fault;
    logic [7:0]  retiredCount;

    logic [15:0] mem [128];
    logic [7:0]  regs [16];

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_sequencer #(.MEM_DEPTH(128), .COUNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .programSelect(programSelect),
        .activeProgram(activeProgram), .address(address), .instruction(instruction),
        .condRegAddr(condRegAddr), .condValue(condValue), .instrOut(instrOut),
        .instrValid(instrValid), .execReady(execReady), .running(running),
        .halted(halted), .fault(fault), .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    assign instruction = mem[address[6:0]];
    assign condValue   = regs[condRegAddr];

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  cond;
        logic [7:0]  exp_addr;
        logic        exp_valid;
        logic        exp_run;
        logic        exp_halt;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    endtask

    task automatic start_prog(input logic [7:0] sel);
        programSelect = sel;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic reached;
        reset = 1'b1; start = 1'b0; execReady = 1'b0; programSelect = 8'h00;
        clear_mem();

        vecs[0]  = '{16'h1100, 8'h00, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'hE000, 8'h00, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h2005, 8'h00, 8'd6,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h20FF, 8'h00, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h20FE, 8'h00, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{16'h207E, 8'h00, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'h207F, 8'h00, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'hC00F, 8'h00, 8'd1,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'hC00F, 8'h05, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'hC00E, 8'h05, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{16'h2100, 8'h00, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{16'hC007, 8'h01, 8'd8,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{16'h5A3C, 8'h00, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0};

        tick(); tick();
        reset = 1'b0;
        chk("rst_address", address, 0);
        chk("rst_valid", instrValid, 0);
        chk("rst_running", running, 0);
        chk("rst_count", retiredCount, 0);

        // Single-word decode table: start, FETCH, DECODE, then inspect the outcome.
        foreach (vecs[k]) begin
            do_reset();
            clear_mem();
            mem[0] = vecs[k].instr;
            for (int r = 0; r < 16; r++) regs[r] = vecs[k].cond;
            execReady = 1'b0;
            start_prog(8'h10);
            tick(); tick();
            chk($sformatf("v%0d_address", k), address, vecs[k].exp_addr);
            chk($sformatf("v%0d_valid", k), instrValid, vecs[k].exp_valid);
            chk($sformatf("v%0d_running", k), running, vecs[k].exp_run);
            chk($sformatf("v%0d_halted", k), halted, vecs[k].exp_halt);
            chk($sformatf("v%0d_fault", k), fault, vecs[k].exp_fault);
            chk($sformatf("v%0d_instrOut", k), instrOut, vecs[k].instr);
            chk($sformatf("v%0d_condRegAddr", k), condRegAddr, {28'd0, vecs[k].instr[7:4]});
        end

        // Issue then halt.
        do_reset(); clear_mem();
        mem[0] = 16'h1100; mem[1] = 16'hE000;
        execReady = 1'b1;
        start_prog(8'h01);
        tick(); tick();
        chk("seq1_valid", instrValid, 1);
        chk("seq1_instrOut", instrOut, 16'h1100);
        tick();
        chk("seq1_addr_next", address, 1);
        chk("seq1_valid_off", instrValid, 0);
        tick(); tick();
        chk("seq1_halted", halted, 1);
        chk("seq1_running", running, 0);
        chk("seq1_count", retiredCount, 1);
        chk("seq1_program", activeProgram, 8'h01);

        // CJUMP at pc=5, condition false then true.
        for (int c = 0; c < 2; c++) begin
            do_reset(); clear_mem();
            mem[0] = 16'h2004; mem[5] = 16'hC072; mem[6] = 16'hE000; mem[8] = 16'hE000;
            regs[7] = (c == 0) ? 8'h00 : 8'h03;
            start_prog(8'h02);
            tick(); tick(); tick(); tick();
            chk($sformatf("cj%0d_address", c), address, (c == 0) ? 6 : 8);
            tick(); tick();
            chk($sformatf("cj%0d_halted", c), halted, 1);
            chk($sformatf("cj%0d_count", c), retiredCount, 0);
        end

        // Backward jump to 3, then a jump below zero from pc=2 faults.
        do_reset(); clear_mem();
        mem[0] = 16'h200B; mem[12] = 16'h20F6; mem[3] = 16'h20FE; mem[2] = 16'h20F0;
        start_prog(8'h03);
        tick(); tick(); tick(); tick();
        chk("jmp_back_addr", address, 3);
        tick(); tick();
        chk("jmp_to2_addr", address, 2);
        tick(); tick();
        chk("jmp_fault", fault, 1);
        chk("jmp_fault_addr", address, 2);
        chk("jmp_fault_running", running, 0);

        // Acceptance at the last legal address faults.
        do_reset(); clear_mem();
        mem[0] = 16'h207E; mem[127] = 16'h1000;
        execReady = 1'b1;
        start_prog(8'h05);
        tick(); tick(); tick(); tick();
        chk("end_valid", instrValid, 1);
        tick();
        chk("end_fault", fault, 1);
        chk("end_addr", address, 127);
        chk("end_count", retiredCount, 1);

        // Stall in ISSUE, release, then reset during a second stall.
        do_reset(); clear_mem();
        mem[0] = 16'h3ABC; mem[1] = 16'h4123;
        execReady = 1'b0;
        start_prog(8'h22);
        tick(); tick();
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("stall%0d_valid", s), instrValid, 1);
            chk($sformatf("stall%0d_instr", s), instrOut, 16'h3ABC);
            chk($sformatf("stall%0d_addr", s), address, 0);
            tick();
        end
        execReady = 1'b1;
        tick();
        execReady = 1'b0;
        chk("release_addr", address, 1);
        chk("release_count", retiredCount, 1);
        chk("release_valid", instrValid, 0);
        tick(); tick();
        chk("stall2_valid", instrValid, 1);
        chk("stall2_condRegAddr", condRegAddr, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_address", address, 0);
        chk("rst2_program", activeProgram, 0);
        chk("rst2_instrOut", instrOut, 0);
        chk("rst2_valid", instrValid, 0);
        chk("rst2_condRegAddr", condRegAddr, 0);
        chk("rst2_running", running, 0);
        chk("rst2_halted", halted, 0);
        chk("rst2_fault", fault, 0);
        chk("rst2_count", retiredCount, 0);
        start_prog(8'h04);
        chk("restart_program", activeProgram, 8'h04);
        chk("restart_addr", address, 0);
        chk("restart_running", running, 1);

        // Two-word loop drives the counter into saturation; selection changes mid-run are ignored.
        do_reset(); clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h20FE;
        execReady = 1'b1;
        start_prog(8'h55);
        reached = 1'b0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            if (i == 100) begin
                programSelect = 8'hAA;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            reached = (retiredCount == 8'hFF);
        end
        start = 1'b0;
        chk("sat_reached", reached, 1);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_count", retiredCount, 8'hFF);
        chk("sat_program", activeProgram, 8'h55);
        chk("sat_running", running, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
